// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides and registered result/flags.
// Define ALU_PIPE_MUL_EN to build the multi-cycle shift-add multiplier (opcode 11).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Err,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a request transfers on a rising edge where In_Valid && In_Ready;
  // a result transfers on a rising edge where Out_Valid && Out_Ready. Both may
  // happen on the same edge, in which case the new result replaces the old one.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif

  logic [1:0]       r_state;
  logic             w_accept;
  logic             w_consume;
  logic             w_mul_start;
  logic             w_mul_load;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_hi_nz;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  assign In_Ready    = (r_state == ST_IDLE) && (!Out_Valid || Out_Ready);
  assign w_accept    = In_Valid && In_Ready;
  assign w_consume   = Out_Valid && Out_Ready;
  assign o_dbg_state = r_state;

  // Bit WIDTH of the widened difference is the borrow.
  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (ALU_Sel)
      4'd0: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: w_res = A & B;
      4'd3: w_res = A | B;
      4'd4: w_res = A ^ B;
      4'd5: w_res = ~A;
      4'd6: begin
        w_res   = {A[WIDTH-2:0], 1'b0};
        w_carry = A[WIDTH-1];
      end
      4'd7: begin
        w_res   = {1'b0, A[WIDTH-1:1]};
        w_carry = A[0];
      end
      4'd8: begin
        w_res   = {A[WIDTH-2:0], A[WIDTH-1]};
        w_carry = A[WIDTH-1];
      end
      4'd9: begin
        w_res   = {A[0], A[WIDTH-1:1]};
        w_carry = A[0];
      end
      4'd10: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      // Opcode 11 lands here only when the multiplier is not built.
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               w_mul_done;

  assign w_mul_start = w_accept && (ALU_Sel == OP_MUL);
  assign w_mul_done  = (r_state == ST_MUL) && (r_cnt == CW'(WIDTH - 1));
  // First HOLD cycle publishes the finished product.
  assign w_mul_load  = (r_state == ST_HOLD) && !Out_Valid;
  assign w_mul_lo    = r_acc[WIDTH-1:0];
  assign w_mul_hi_nz = |r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_cnt    <= '0;
    end else if (r_state == ST_MUL) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`else
  assign w_mul_start = 1'b0;
  assign w_mul_load  = 1'b0;
  assign w_mul_lo    = '0;
  assign w_mul_hi_nz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_mul_start) r_state <= 2'd1;
`ifdef ALU_PIPE_MUL_EN
        ST_MUL:  if (w_mul_done) r_state <= ST_HOLD;
`endif
        ST_HOLD: if (w_consume) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Out_Valid <= 1'b0;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Err       <= 1'b0;
    end else if (w_accept && !w_mul_start) begin
      Out_Valid <= 1'b1;
      ALU_Out   <= w_res;
      CarryOut  <= w_carry;
      Zero      <= (w_res == '0);
      Overflow  <= w_ovf;
      Err       <= w_err;
    end else if (w_mul_load) begin
      Out_Valid <= 1'b1;
      ALU_Out   <= w_mul_lo;
      CarryOut  <= w_mul_hi_nz;
      Zero      <= (w_mul_lo == '0);
      Overflow  <= 1'b0;
      Err       <= 1'b0;
    end else if (w_consume) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure, reset abort and
// randomized operations scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 8;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] ALU_Out;
  logic         CarryOut;
  logic         Zero;
  logic         Overflow;
  logic         Err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+3:0] exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow),
    .Err(Err), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: result and flags from plain integer arithmetic.
  function automatic logic [W+3:0] model(input longint a, input longint b, input int sel);
    longint full, half, sa, sb, r, s;
    logic c, z, o, e;
    logic [W-1:0] rv;
    full = longint'(1) << W;
    half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    c = 1'b0; o = 1'b0; e = 1'b0; r = 0;
    case (sel)
      0:  begin r = a + b; c = (r >= full); s = sa + sb; o = (s >= half) || (s < -half); end
      1:  begin r = a - b; c = (a < b); s = sa - sb; o = (s >= half) || (s < -half); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = full - 1 - a;
      6:  begin r = a * 2; c = (a >= half); end
      7:  begin r = a / 2; c = (a % 2 == 1); end
      8:  begin r = a * 2 + ((a >= half) ? 1 : 0); c = (a >= half); end
      9:  begin r = a / 2 + ((a % 2 == 1) ? half : 0); c = (a % 2 == 1); end
      10: r = (a < b) ? 1 : 0;
      11: begin
        if (MUL_ON) begin r = a * b; c = (r >= full); end
        else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    r  = ((r % full) + full) % full;
    rv = r[W-1:0];
    z  = (r == 0);
    return {rv, c, z, o, e};
  endfunction

  // Driver: waits (bounded) for In_Ready, presents one request, and for a
  // multiply optionally waits for the result while hammering ignored requests.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sel, input bit wait_res);
    int lat;
    #1;
    for (int i = 0; i < 4 && In_Ready !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_in_ready"}, In_Ready, 1);
    In_Valid = 1'b1; A = a; B = b; ALU_Sel = sel;
    exp_q.push_back(model(a, b, sel));
    @(negedge clk);
    In_Valid = 1'b0; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    if (MUL_ON && sel == 4'd11 && wait_res) begin
      lat = 0;
      while (Out_Valid !== 1'b1 && lat < W + 6) begin
        chk({tag, "_busy_in_ready"}, In_Ready, 0);
        In_Valid = 1'b1; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
        @(negedge clk);
        lat++;
      end
      In_Valid = 1'b0;
      chk({tag, "_latency"}, lat, W + 1);
    end
  endtask

  // Scoreboard: compare the visible result against the oldest expectation.
  task automatic check_out(input string tag);
    logic [W+3:0] e;
    chk({tag, "_valid"}, Out_Valid, 1);
    chk({tag, "_q_nonempty"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, ALU_Out, e[W+3:4]);
      chk({tag, "_carry"}, CarryOut, e[3]);
      chk({tag, "_zero"}, Zero, e[2]);
      chk({tag, "_ovf"}, Overflow, e[1]);
      chk({tag, "_err"}, Err, e[0]);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(127);
      3: return W'(128);
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    // Reset with a simultaneous request: reset must win.
    rst = 1'b1; In_Valid = 1'b1; A = 8'd9; B = 8'd9; ALU_Sel = 4'd0; Out_Ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", Out_Valid, 0);
    chk("rst_out", ALU_Out, 0);
    chk("rst_carry", CarryOut, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_err", Err, 0);
    rst = 1'b0; In_Valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_still_idle", Out_Valid, 0);

    do_op("add10_5", 8'd10, 8'd5, 4'd0, 1'b1);
    chk("add10_5_const", ALU_Out, 15);
    chk("add10_5_cconst", CarryOut, 0);
    check_out("add10_5");

    do_op("add200_100", 8'd200, 8'd100, 4'd0, 1'b1);
    chk("add200_100_const", ALU_Out, 44);
    chk("add200_100_cconst", CarryOut, 1);
    check_out("add200_100");

    do_op("sub5_10", 8'd5, 8'd10, 4'd1, 1'b1);
    chk("sub5_10_const", ALU_Out, 251);
    chk("sub5_10_cconst", CarryOut, 1);
    chk("sub5_10_oconst", Overflow, 0);
    check_out("sub5_10");

    do_op("add127_1", 8'd127, 8'd1, 4'd0, 1'b1);
    chk("add127_1_const", ALU_Out, 128);
    chk("add127_1_oconst", Overflow, 1);
    check_out("add127_1");

    do_op("mul20_13", 8'd20, 8'd13, 4'd11, 1'b1);
    chk("mul20_13_const", ALU_Out, MUL_ON ? 4 : 0);
    chk("mul20_13_cconst", CarryOut, MUL_ON ? 1 : 0);
    chk("mul20_13_econst", Err, MUL_ON ? 0 : 1);
    check_out("mul20_13");

    // Backpressure hold, then consume and accept on the same edge.
    do_op("xor10_5", 8'd10, 8'd5, 4'd4, 1'b1);
    Out_Ready = 1'b0;
    check_out("xor10_5");
    for (int i = 0; i < 5; i++) begin
      In_Valid = 1'b1; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", Out_Valid, 1);
      chk("hold_out", ALU_Out, 15);
      chk("hold_in_ready", In_Ready, 0);
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    do_op("sub3_3", 8'd3, 8'd3, 4'd1, 1'b1);
    chk("sub3_3_const", ALU_Out, 0);
    chk("sub3_3_zconst", Zero, 1);
    check_out("sub3_3");

    // Reset in the middle of a multiply discards it.
    do_op("mul_abort", 8'd20, 8'd13, 4'd11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_valid", Out_Valid, 0);
    chk("abort_out", ALU_Out, 0);
    chk("abort_carry", CarryOut, 0);
    chk("abort_zero", Zero, 0);
    chk("abort_err", Err, 0);
    @(negedge clk);
    chk("abort_in_ready", In_Ready, 1);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", Out_Valid, 0);
    end
    do_op("inv13", 8'($urandom), 8'($urandom), 4'd13, 1'b1);
    chk("inv13_const", ALU_Out, 0);
    chk("inv13_econst", Err, 1);
    check_out("inv13");

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      int k;
      string tag;
      tag = $sformatf("rnd%0d", i);
      do_op(tag, pick(), pick(), 4'($urandom_range(0, 15)), 1'b1);
      k = $urandom_range(0, 3);
      Out_Ready = 1'b0;
      for (int j = 0; j < k; j++) begin
        In_Valid = 1'b1; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
        @(negedge clk);
        chk({tag, "_stall_valid"}, Out_Valid, 1);
        chk({tag, "_stall_out"}, ALU_Out, exp_q[0][W+3:4]);
        chk({tag, "_stall_in_ready"}, In_Ready, 0);
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      check_out(tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
